// File: rtl/aes_word_assembler_if.sv
// Word-input handshake between a 32-bit word source and the AES word assembler.
// The source holds word_i/key_sel_i stable while word_valid_i is high and word_ready_o is low.
interface aes_word_assembler_if #(
  parameter int WORD_W = 32
) ();
  logic              word_valid_i;
  logic              word_ready_o;
  logic [WORD_W-1:0] word_i;
  logic              key_sel_i;

  modport master (
    output word_valid_i,
    output word_i,
    output key_sel_i,
    input  word_ready_o
  );

  modport slave (
    input  word_valid_i,
    input  word_i,
    input  key_sel_i,
    output word_ready_o
  );
endinterface

// File: rtl/aes_word_assembler.sv
// Input-side deserializer for the AES core: assembles a text block and a key from
// 32-bit words (first word lands in the low slot) and pulses ld_o once both are complete.
module aes_word_assembler #(
  parameter  int WORD_W = 32,
  parameter  int NWORDS = 4,
  localparam int BLK_W  = WORD_W * NWORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_word_assembler_if.slave  wb,
  input  logic                 core_busy_i,
  output logic [BLK_W-1:0]     text_o,
  output logic [BLK_W-1:0]     key_o,
  output logic                 key_valid_o,
  output logic                 ld_o
);

  localparam int            CW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] kcnt;
  logic          ready;
  logic          text_hs;
  logic          key_hs;

  // Ready depends only on state and the word's destination, never on valid.
  always_comb begin
    ready = 1'b0;
    case (state)
      COLLECT: ready = 1'b1;
      FULL:    ready = wb.key_sel_i;
      default: ready = 1'b0;
    endcase
  end

  assign wb.word_ready_o = ready;
  assign text_hs         = wb.word_valid_i & ready & ~wb.key_sel_i;
  assign key_hs          = wb.word_valid_i & ready &  wb.key_sel_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      tcnt        <= '0;
      kcnt        <= '0;
      text_o      <= '0;
      key_o       <= '0;
      key_valid_o <= 1'b0;
      ld_o        <= 1'b0;
    end else begin
      ld_o <= 1'b0;

      // key_valid_o is only ever high with kcnt back at 0, so the first word of a
      // new key lands in slot 0 and drops key_valid_o in the same edge.
      if (key_hs) begin
        key_o[kcnt*WORD_W +: WORD_W] <= wb.word_i;
        kcnt        <= (kcnt == LAST) ? '0 : kcnt + CW'(1);
        key_valid_o <= (kcnt == LAST);
      end

      if (text_hs) begin
        text_o[tcnt*WORD_W +: WORD_W] <= wb.word_i;
        tcnt <= (tcnt == LAST) ? '0 : tcnt + CW'(1);
      end

      case (state)
        COLLECT: begin
          if (text_hs && (tcnt == LAST))
            state <= FULL;
        end
        FULL: begin
          // A key word arriving this cycle may be starting a new key; wait for it to settle.
          if (key_valid_o && !core_busy_i && !key_hs) begin
            state <= LOAD;
            ld_o  <= 1'b1;
          end
        end
        LOAD:    state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
